// File: rtl/bch_syndrome_sched.sv
// Round-robin scheduler time-sharing one bch_syndrome unit between NCH codeword sources.
// Define BCH_SCHED_ERRFLAG_EN to add out_err (OR of the captured syndrome bits).
module bch_syndrome_sched #(
  parameter int CODE_BITS = 15,  // BCH_CODE_BITS(P) of the attached unit
  parameter int BITS      = 1,
  parameter int NCH       = 4,
  parameter int SZ        = 8,   // BCH_SYNDROMES_SZ(P) of the attached unit
  parameter int CW        = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      in_valid,
  input  logic [NCH*BITS-1:0] in_data,
  output logic [NCH-1:0]      in_ready,
  output logic                syn_start,
  output logic                syn_ce,
  output logic [BITS-1:0]     syn_data,
  input  logic                syn_ready,
  input  logic                syn_done,
  input  logic [SZ-1:0]       syn_syndromes,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_ch,
  output logic [SZ-1:0]       out_syndromes
`ifdef BCH_SCHED_ERRFLAG_EN
  ,
  output logic                out_err
`endif
);

  localparam int W   = (CODE_BITS + BITS - 1) / BITS;
  localparam int WCW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH} state_t;

  state_t          state_q;
  logic [CW-1:0]   cur_q, cur_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WCW-1:0]  wc_q;
  logic            out_valid_q;
  logic [CW-1:0]   out_ch_q;
  logic [SZ-1:0]   out_syn_q;
`ifdef BCH_SCHED_ERRFLAG_EN
  logic            out_err_q;
`endif

  logic [NCH-1:0]  req_rot;
  logic [CW:0]     pick_sum;
  logic            pick_found;
  logic            last_word;
  logic            capture;
  logic [BITS-1:0] ch_word [NCH];

  // Rotate requests so bit 0 is rr_ptr; the first set bit is the winner.
  always_comb begin
    req_rot    = NCH'({in_valid, in_valid} >> rr_ptr_q);
    pick_found = 1'b0;
    pick_sum   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!pick_found && req_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr_q} + (CW+1)'(k);
      end
    end
    if (pick_sum >= (CW+1)'(NCH)) pick_sum = pick_sum - (CW+1)'(NCH);
    cur_d = pick_sum[CW-1:0];
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) ch_word[i] = in_data[i*BITS +: BITS];
  end

  assign last_word = (wc_q == WCW'(W - 1));
  assign rr_ptr_d  = (cur_q == CW'(NCH - 1)) ? '0 : cur_q + CW'(1);

  always_comb begin
    in_ready  = '0;
    syn_ce    = 1'b0;
    syn_start = 1'b0;
    syn_data  = '0;
    unique case (state_q)
      ST_STREAM: begin
        in_ready[cur_q] = in_valid[cur_q];
        syn_ce          = in_valid[cur_q];
        syn_start       = in_valid[cur_q] && (wc_q == '0);
        if (in_valid[cur_q]) syn_data = ch_word[cur_q];
      end
      // Drain only while the result register is free to take the answer.
      ST_FLUSH: syn_ce = !out_valid_q || out_ready;
      default: ;
    endcase
  end

  assign capture = (state_q == ST_FLUSH) && syn_done && syn_ce;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      rr_ptr_q    <= '0;
      wc_q        <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_syn_q   <= '0;
`ifdef BCH_SCHED_ERRFLAG_EN
      out_err_q   <= 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_found && syn_ready) begin
            cur_q   <= cur_d;
            wc_q    <= '0;
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (in_valid[cur_q]) begin
            if (last_word) begin
              rr_ptr_q <= rr_ptr_d;
              state_q  <= ST_FLUSH;
            end else begin
              wc_q <= wc_q + WCW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (capture) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= cur_q;
            out_syn_q   <= syn_syndromes;
`ifdef BCH_SCHED_ERRFLAG_EN
            out_err_q   <= |syn_syndromes;
`endif
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_ch        = out_ch_q;
  assign out_syndromes = out_syn_q;
`ifdef BCH_SCHED_ERRFLAG_EN
  assign out_err       = out_err_q;
`endif

endmodule
